// File: rtl/friscv_mem_arbiter_pkg.sv
// friscv_mem_arbiter_pkg: state encoding and grant identifiers shared by the memory arbiter
package friscv_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, INST, DATA, RESP} arb_state_t;
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;
endpackage

// File: rtl/friscv_watchdog.sv
// friscv_watchdog: counts cycles of an open memory transaction and flags when the limit is reached
module friscv_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic aclk,
  input  logic srst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  logic [W-1:0] count_q, count_d;
  // expiry is reported while the count sits at the limit; a zero limit never expires
  always_comb begin
    expired = (TIMEOUT != 0) && (count_q == LIMIT);
    count_d = clear ? '0 : (run && !expired) ? count_q + 1'b1 : count_q;
  end
  // count register
  always_ff @(posedge aclk) begin
    if (srst) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/friscv_mem_arbiter.sv
// friscv_mem_arbiter: round-robin sharing of one memory port between instruction fetch and load/store
module friscv_mem_arbiter
  import friscv_mem_arbiter_pkg::*;
#(
  parameter int ADDRW = 16,
  parameter int XLEN = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              aclk,
  input  logic              srst,
  input  logic              inst_en,
  input  logic [ADDRW-1:0]  inst_addr,
  output logic [XLEN-1:0]   inst_rdata,
  output logic              inst_ready,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [ADDRW-1:0]  mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN/8-1:0] mem_strb,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDRW-1:0]  ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic [XLEN/8-1:0] ram_strb,
  input  logic [XLEN-1:0]   ram_rdata,
  input  logic              ram_ready,
  output logic              arb_err
);
  arb_state_t state_q, state_d;
  logic last_q, last_d, gnt_q, gnt_d, err_q, err_d;
  logic ram_en_q, ram_en_d, ram_wr_q, ram_wr_d;
  logic [ADDRW-1:0] ram_addr_q, ram_addr_d;
  logic [XLEN-1:0] ram_wdata_q, ram_wdata_d, rdata_q, rdata_d;
  logic [XLEN/8-1:0] ram_strb_q, ram_strb_d;
  logic pick, grant, run, done, expired;

  friscv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .aclk(aclk),
    .srst(srst),
    .clear(grant),
    .run(run),
    .expired(expired)
  );

  // arbitration: a lone requester wins, contention goes to whoever was not served last
  always_comb begin
    pick = (inst_en && (!mem_en || last_q == GRANT_DATA)) ? GRANT_INST : GRANT_DATA;
    grant = (state_q == IDLE) && (inst_en || mem_en);
    run = (state_q == INST) || (state_q == DATA);
    done = run && (ram_ready || expired);
  end

  // next state: completion or watchdog abort both funnel through the single response cycle
  always_comb begin
    state_d = grant ? (pick == GRANT_INST ? INST : DATA) :
              done ? RESP :
              (state_q == RESP) ? IDLE : state_q;
  end

  // datapath: memory request fields are captured at grant and frozen until completion
  always_comb begin
    ram_en_d = grant ? 1'b1 : done ? 1'b0 : ram_en_q;
    ram_wr_d = grant ? (pick == GRANT_DATA && mem_wr) : ram_wr_q;
    ram_addr_d = grant ? (pick == GRANT_INST ? inst_addr : mem_addr) : ram_addr_q;
    ram_wdata_d = grant ? (pick == GRANT_INST ? '0 : mem_wdata) : ram_wdata_q;
    ram_strb_d = grant ? (pick == GRANT_INST ? '1 : mem_strb) : ram_strb_q;
    gnt_d = grant ? pick : gnt_q;
    last_d = done ? gnt_q : last_q;
    rdata_d = done ? ((ram_ready && !ram_wr_q) ? ram_rdata : '0) : rdata_q;
    err_d = done ? !ram_ready : err_q;
  end

  // state and datapath registers; the pointer resets so that inst wins the first tie
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= IDLE;
      last_q <= GRANT_DATA;
      gnt_q <= GRANT_INST;
      err_q <= 1'b0;
      ram_en_q <= 1'b0;
      ram_wr_q <= 1'b0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      ram_strb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      err_q <= err_d;
      ram_en_q <= ram_en_d;
      ram_wr_q <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_strb_q <= ram_strb_d;
      rdata_q <= rdata_d;
    end
  end

  // outputs: the winner's ready and data are only live during the response cycle
  always_comb begin
    inst_ready = (state_q == RESP) && (gnt_q == GRANT_INST);
    mem_ready = (state_q == RESP) && (gnt_q == GRANT_DATA);
    inst_rdata = inst_ready ? rdata_q : '0;
    mem_rdata = mem_ready ? rdata_q : '0;
    arb_err = (state_q == RESP) && err_q;
    ram_en = ram_en_q;
    ram_wr = ram_wr_q;
    ram_addr = ram_addr_q;
    ram_wdata = ram_wdata_q;
    ram_strb = ram_strb_q;
  end
endmodule
